// File: rtl/psum_collector.sv
// Output stage behind the PE array: saturating cross-pass accumulation of N row
// results, then shift/round/ReLU/clamp requantisation streamed out one row per handshake.
module psum_collector #(
    parameter int I_WIDTH     = 8,
    parameter int F_WIDTH     = 8,
    parameter int N           = 3,
    parameter int ACC_WIDTH   = I_WIDTH + F_WIDTH + 4,
    parameter int O_WIDTH     = 8,
    parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N*(I_WIDTH+F_WIDTH)-1:0]   psum_i,
    input  logic                             psum_valid_i,
    input  logic                             first_pass_i,
    input  logic                             last_pass_i,
    output logic                             psum_ready_o,
    input  logic [SHIFT_WIDTH-1:0]           quant_shift_i,
    input  logic                             relu_en_i,
    output logic signed [O_WIDTH-1:0]        out_data_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic                             out_last_o,
    output logic                             sat_o,
    output logic                             drop_err_o
);
    localparam int PW   = I_WIDTH + F_WIDTH;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'((1 << (O_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = -OUT_MAX - 1;

    typedef enum logic [1:0] {ACCUM, LOAD, DRAIN} state_t;

    state_t                       r_state, w_state_nxt;
    logic signed [ACC_WIDTH-1:0]  r_acc [N];
    logic [IDXW-1:0]              r_idx;

    logic                         w_accept;
    logic                         w_hs;
    logic                         w_idx_last;
    logic signed [ACC_WIDTH:0]    w_sum     [N];
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt [N];
    logic [N-1:0]                 w_acc_sat;
    logic [IDXW-1:0]              w_sel_idx;
    logic signed [ACC_WIDTH-1:0]  w_sel;
    logic signed [ACC_WIDTH:0]    w_ext, w_rnd, w_y;
    logic signed [O_WIDTH-1:0]    w_post;
    logic                         w_post_sat;

    assign psum_ready_o = (r_state == ACCUM);
    assign w_accept     = psum_valid_i && psum_ready_o;
    assign w_hs         = (r_state == DRAIN) && out_valid_o && out_ready_i;
    assign w_idx_last   = (r_idx == IDXW'(N-1));
    assign out_last_o   = (r_state == DRAIN) && w_idx_last;

    // Sum in ACC_WIDTH+1 bits so overflow is visible before clamping.
    always_comb begin
        for (int g = 0; g < N; g++) begin
            w_sum[g]     = (ACC_WIDTH+1)'(r_acc[g]) + (ACC_WIDTH+1)'($signed(psum_i[g*PW +: PW]));
            w_acc_sat[g] = 1'b0;
            if (first_pass_i) begin
                w_acc_nxt[g] = ACC_WIDTH'($signed(psum_i[g*PW +: PW]));
            end else if (w_sum[g] > ACC_MAX) begin
                w_acc_nxt[g] = ACC_WIDTH'(ACC_MAX);
                w_acc_sat[g] = 1'b1;
            end else if (w_sum[g] < ACC_MIN) begin
                w_acc_nxt[g] = ACC_WIDTH'(ACC_MIN);
                w_acc_sat[g] = 1'b1;
            end else begin
                w_acc_nxt[g] = ACC_WIDTH'(w_sum[g]);
            end
        end
    end

    // Row to be registered next: row 0 in LOAD, idx+1 on a DRAIN handshake.
    assign w_sel_idx = (r_state == LOAD) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++)
            if (w_sel_idx == IDXW'(i)) w_sel = r_acc[i];
    end

    always_comb begin
        w_ext = (ACC_WIDTH+1)'(w_sel);
        w_rnd = (ACC_WIDTH+1)'(1) << (quant_shift_i - 1'b1);
        if (quant_shift_i == '0) w_y = w_ext;
        else                     w_y = (w_ext + w_rnd) >>> quant_shift_i;
        if (relu_en_i && w_y < 0) w_y = '0;
        w_post_sat = 1'b0;
        if (w_y > OUT_MAX) begin
            w_post     = O_WIDTH'(OUT_MAX);
            w_post_sat = 1'b1;
        end else if (w_y < OUT_MIN) begin
            w_post     = O_WIDTH'(OUT_MIN);
            w_post_sat = 1'b1;
        end else begin
            w_post = O_WIDTH'(w_y);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_accept && last_pass_i) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = DRAIN;
            DRAIN:   if (w_hs && w_idx_last) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ACCUM;
            r_idx       <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            sat_o       <= 1'b0;
            drop_err_o  <= 1'b0;
            for (int g = 0; g < N; g++) r_acc[g] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                for (int g = 0; g < N; g++) r_acc[g] <= w_acc_nxt[g];
                if (|w_acc_sat) sat_o <= 1'b1;
            end
            if (psum_valid_i && !psum_ready_o) drop_err_o <= 1'b1;
            if (r_state == LOAD) begin
                r_idx       <= '0;
                out_data_o  <= w_post;
                out_valid_o <= 1'b1;
                if (w_post_sat) sat_o <= 1'b1;
            end else if (w_hs) begin
                if (!w_idx_last) begin
                    r_idx      <= r_idx + 1'b1;
                    out_data_o <= w_post;
                    if (w_post_sat) sat_o <= 1'b1;
                end else begin
                    out_valid_o <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/psum_collector.md
# psum_collector

Output stage downstream of the PE array. Captures the N row results (`output_pe_o` of the last-column PEs) once per pass and accumulates them across passes (input channels / kernel tiles) in a saturating accumulator bank. After the last pass, it requantises each row result with shift, round, optional ReLU and clamp. It then streams the N bytes out over a valid/ready handshake.

## Interface
- `I_WIDTH`, 8, feature width (matches PE)
- `F_WIDTH`, 8, weight width (matches PE)
- `N`, 3, number of PE rows / results per pass
- `ACC_WIDTH`, `I_WIDTH+F_WIDTH+4`, signed accumulator width
- `O_WIDTH`, 8, signed output width
- `SHIFT_WIDTH`, `$clog2(ACC_WIDTH)`, width of requant shift
- `clk_i`  in  1  clock; all state on rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `psum_i`  in  `N*(I_WIDTH+F_WIDTH)`  packed signed row results, row 0 in LSBs
- `psum_valid_i`  in  1  one-cycle strobe: all N row results valid
- `first_pass_i`  in  1  qualified by `psum_valid_i`; overwrite instead of add
- `last_pass_i`  in  1  qualified by `psum_valid_i`; drain after this update
- `psum_ready_o`  out  1  collector accepts a strobe this cycle
- `quant_shift_i`  in  `SHIFT_WIDTH`  arithmetic right shift; static during drain
- `relu_en_i`  in  1  clamp negatives to 0; static during drain
- `out_data_o`  out  `O_WIDTH`  signed requantised result
- `out_valid_o`  out  1  `out_data_o` valid
- `out_ready_i`  in  1  consumer accepts
- `out_last_o`  out  1  marks row N-1 of a drain
- `sat_o`  out  1  sticky: any accumulator or output saturation since reset
- `drop_err_o`  out  1  sticky: strobe arrived while `psum_ready_o`=0

## Operation
- States: ACCUM, LOAD, DRAIN. Reset puts the block in ACCUM.
- Reset values:
  - accumulators 0
  - `out_data_o`=0, `out_valid_o`=0, `out_last_o`=0
  - `psum_ready_o`=1
  - `sat_o`=0, `drop_err_o`=0
  - row index 0
- ACCUM: `psum_ready_o`=1. An accept is `psum_valid_i`&`psum_ready_o`. On accept, for each row r:
  - `acc[r]` <= `first_pass_i` ? sext(psum_r) : sat(`acc[r]`+sext(psum_r)).
  - The sum is formed in ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. A clamp sets `sat_o`.
  - If `last_pass_i`=1, go to LOAD.
- `first_pass_i`=`last_pass_i`=1 on the same strobe is a valid single-pass result.
- LOAD (1 cycle): `psum_ready_o`=0. Register post(acc[0]) into `out_data_o`, set idx=0 and `out_valid_o`=1, then go to DRAIN.
- DRAIN: `psum_ready_o`=0; `out_last_o`=(idx==N-1). On `out_valid_o`&`out_ready_i`:
  - If idx<N-1: idx++ and `out_data_o` <= post(acc[idx+1]); `out_valid_o` stays 1.
  - If idx==N-1: `out_valid_o`<=0, go to ACCUM.
- Without a handshake, `out_data_o`, `out_last_o` and `out_valid_o` hold.
- post(x), for s=`quant_shift_i`:
  - s=0: y=x.
  - s>0: y=(x+2^(s-1))>>>s in ACC_WIDTH+1 bits (round half up, floor semantics for negatives).
  - If `relu_en_i` and y<0: y=0.
  - Clamp y to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1]; a clamp sets `sat_o`.
- A strobe while `psum_ready_o`=0 is discarded: accumulators are unchanged and `drop_err_o` is set. The PE array cannot stall, so the scheduler must not issue passes during a drain.
- If the accumulators are used without any `first_pass_i`, they add onto their current contents (0 after reset).

## Timing
- Accept at edge t updates the accumulators at edge t.
- Last-pass accept at edge t:
  - `psum_ready_o` low from t.
  - First `out_valid_o` at edge t+2 (LOAD at t+1).
- With `out_ready_i` held 1, one result per cycle. Row N-1 handshakes at edge t+1+N.
- `psum_ready_o`=1 the cycle after the final handshake; a new accept is possible at edge t+2+N.
- Asserting `rst_i` (low) at any point, including mid-DRAIN, immediately forces all outputs to reset values. No partial drain resumes after release.

## Test plan
- Single pass (N=3, defaults): psum {10,-5,300}, first=last=1, shift 0, ReLU off, ready=1 -> outputs 10,-5,127 on consecutive cycles; `out_last_o` only on 127; `sat_o`=1.
- Three passes: row0 100 each, row1 -7 each, row2 0; shift 2; ReLU on -> 75, 0, 0.
- Same three passes, ReLU off -> row1 = (-21+2)>>>2 = -5.
- Backpressure: `out_ready_i`=0 for 5 cycles after first valid -> `out_data_o` stable, `psum_ready_o`=0. A strobe in that window -> `drop_err_o`=1, accumulators unchanged, and the remaining drain values are correct.
- Accumulator saturation: row0 psum 32767 for 17 passes -> acc clamps at 524287, `sat_o`=1; output with shift 12 -> 127 (clamped).
- Reset mid-DRAIN after 1 of 3 handshakes -> `out_valid_o`=0 asynchronously, `psum_ready_o`=1 after release. A following single pass {1,2,3} -> 1,2,3.
